// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one byte-enabled data RAM between two requesters
module dmem_arbiter #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          AW          = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [31:0]   m0_addr,
  input  logic [3:0]    m0_we,
  input  logic [31:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic [31:0]   m1_addr,
  input  logic [3:0]    m1_we,
  input  logic [31:0]   m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          m1_err,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);
  logic        last_gnt, p_valid, p_port, p_err;
  logic [31:0] off0, off1;
  logic [3:0]  sel_we;
  logic        l0, l1, sel_legal, gnt;

  function automatic logic legal(input logic [31:0] off, input logic [3:0] we);
    legal = off < 32'(4 * DEPTH_WORDS) &&
      (we == 4'b0000 || we == 4'b1111 ||
       (we == 4'b0001 && off[1:0] == 2'd0) || (we == 4'b0010 && off[1:0] == 2'd1) ||
       (we == 4'b0100 && off[1:0] == 2'd2) || (we == 4'b1000 && off[1:0] == 2'd3) ||
       (we == 4'b0011 && off[1:0] == 2'd0) || (we == 4'b1100 && off[1:0] == 2'd2));
  endfunction

  assign off0      = m0_addr - ADDR_BASE;
  assign off1      = m1_addr - ADDR_BASE;
  assign l0        = legal(off0, m0_we);
  assign l1        = legal(off1, m1_we);
  // on a tie the port that did not win last time gets the slot
  assign m0_gnt    = !reset && m0_req && (!m1_req || last_gnt);
  assign m1_gnt    = !reset && m1_req && (!m0_req || !last_gnt);
  assign gnt       = m0_gnt || m1_gnt;
  assign sel_we    = m1_gnt ? m1_we : m0_we;
  assign sel_legal = m1_gnt ? l1 : l0;
  assign mem_en    = gnt && sel_legal;
  assign mem_we    = mem_en ? sel_we : 4'b0000;
  assign mem_addr  = mem_en ? (m1_gnt ? off1[AW+1:2] : off0[AW+1:2]) : '0;
  assign mem_wdata = mem_en ? (m1_gnt ? m1_wdata : m0_wdata) : '0;
  assign m0_rvalid = !reset && p_valid && !p_port;
  assign m1_rvalid = !reset && p_valid && p_port;
  assign m0_err    = m0_rvalid && p_err;
  assign m1_err    = m1_rvalid && p_err;
  assign m0_rdata  = (m0_rvalid && !p_err) ? mem_rdata : '0;
  assign m1_rdata  = (m1_rvalid && !p_err) ? mem_rdata : '0;

  // legal writes complete at grant; only reads and rejected accesses respond
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= 1'b1;
      p_valid  <= 1'b0;
      p_port   <= 1'b0;
      p_err    <= 1'b0;
    end else begin
      if (gnt) last_gnt <= m1_gnt;
      p_valid <= gnt && (!sel_legal || sel_we == 4'b0000);
      p_port  <= m1_gnt;
      p_err   <= !sel_legal;
    end
  end
endmodule
